cargador_mascara: RTL and testbench
===================================

CARGADOR_MASCARA -- requirements
Module: cargador_mascara

Interface
REQ-001 SHALL have parameter BITS_DIRECCION, default 16, width of the mask memory address.
REQ-002 SHALL have parameter BITS_DATOS, default 8, width of one mask coefficient.
REQ-003 SHALL have parameter BITS_TAMANO, default 3, width of the mask side-length input.
REQ-004 SHALL have parameter TAMANO_MAX, default 7, largest legal mask side N.
REQ-005 SHALL have parameter BITS_INDICE, default 6, coefficient index width; TAMANO_MAX*TAMANO_MAX <= 2^BITS_INDICE.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port tamano_mascara  input  BITS_TAMANO  mask side N (mask is NxN).
REQ-009 SHALL have port direccion_mem_mascara  input  BITS_DIRECCION  base address of coefficient 0.
REQ-010 SHALL have port iniciar_lectura  input  1  start request.
REQ-011 SHALL have port cancelar  input  1  abort the current load.
REQ-012 SHALL have port lectura_completada  input  1  memory acknowledge; dato_mem valid in the same cycle.
REQ-013 SHALL have port dato_mem  input  BITS_DATOS  memory read data.
REQ-014 SHALL have port direccion_mem  output  BITS_DIRECCION  memory read address.
REQ-015 SHALL have port leer  output  1  memory read request.
REQ-016 SHALL have port coef_dato  output  BITS_DATOS  delivered coefficient.
REQ-017 SHALL have port indice_coef  output  BITS_INDICE  row-major index of coef_dato.
REQ-018 SHALL have port coef_valido  output  1  one-cycle strobe qualifying coef_dato and indice_coef.
REQ-019 SHALL have port ocupado  output  1  high in every state except E_INICIO.
REQ-020 SHALL have port listo  output  1  one-cycle pulse after the last coefficient.
REQ-021 SHALL have port error  output  1  one-cycle pulse on an illegal size.

Function
REQ-022 SHALL implement a Moore FSM with states E_INICIO, E_CALCULO, E_PEDIR, E_ENTREGAR and E_FIN; all outputs SHALL be registered or decoded from state.
REQ-023 In E_INICIO, iniciar_lectura=1 SHALL latch tamano_mascara and direccion_mem_mascara, clear the index, and go to E_CALCULO; iniciar_lectura SHALL be ignored in every other state.
REQ-024 E_CALCULO SHALL check N: N=0, N even, or N>TAMANO_MAX SHALL pulse error for one cycle and return to E_INICIO with leer never asserted; otherwise total=N*N SHALL be registered and the FSM SHALL go to E_PEDIR.
REQ-025 In E_PEDIR, leer=1 and direccion_mem=(base+index) mod 2^BITS_DIRECCION; both SHALL be held stable until lectura_completada=1, for any number of wait cycles.
REQ-026 On lectura_completada=1 in E_PEDIR, dato_mem SHALL be captured and the FSM SHALL go to E_ENTREGAR; leer SHALL be 0 in the following cycle.
REQ-027 In E_ENTREGAR, coef_valido=1 for exactly one cycle with coef_dato=captured data and indice_coef=index.
REQ-028 From E_ENTREGAR: if index=total-1, go to E_FIN; otherwise increment index and return to E_PEDIR. Minimum of 2 cycles per coefficient.
REQ-029 E_FIN SHALL pulse listo for one cycle and return to E_INICIO; a new iniciar_lectura SHALL be accepted in the following cycle.
REQ-030 lectura_completada outside E_PEDIR SHALL be ignored.
REQ-031 cancelar=1 in any state other than E_INICIO SHALL force E_INICIO on the next edge; leer, coef_valido and listo SHALL be 0 from that edge, and error SHALL NOT pulse. cancelar has priority over lectura_completada in the same cycle.
REQ-032 Address arithmetic SHALL wrap modulo 2^BITS_DIRECCION without a flag.
REQ-033 coef_dato and indice_coef SHALL hold their last values when coef_valido=0.

Reset
REQ-034 reset=0 SHALL asynchronously force E_INICIO and clear the index, total, latched base and size, and all outputs (direccion_mem, leer, coef_dato, indice_coef, coef_valido, ocupado, listo, error) to 0.
REQ-035 A reset asserted mid-load SHALL abandon the load with no listo; after release, the block SHALL accept iniciar_lectura on the first clock edge.

Verification
REQ-036 N=3, base 0x0100, 1-cycle acknowledge -> addresses 0x0100..0x0108 and 9 coef_valido pulses with indices 0..8 matching memory; listo 1 cycle after the 9th pulse.
REQ-037 N=4, then N=0, then N=9 -> one error pulse each; leer stays 0; ocupado high for 2 cycles.
REQ-038 N=3, base 0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000..0x0006.
REQ-039 lectura_completada delayed 3 cycles on coefficient 4 -> leer and direccion_mem stable for 4 cycles; data and index still correct.
REQ-040 cancelar during the 5th E_PEDIR, asserted together with lectura_completada -> no coef_valido for index 4 and no listo; a new N=5 load then completes with 25 coefficients.
REQ-041 reset=0 asynchronously mid-load (between clock edges) -> all outputs 0 immediately; a normal N=3 load then succeeds.

Source files
------------

// File: rtl/cargador_mascara_if.sv
// cargador_mascara_if: read bus between the mask loader (master) and the coefficient memory (slave)
//   direccion_mem      master->slave  read address
//   leer               master->slave  read request, held until lectura_completada
//   lectura_completada slave->master  acknowledge, dato_mem valid in the same cycle
//   dato_mem           slave->master  read data
interface cargador_mascara_if #(
  parameter int BITS_DIRECCION = 16,
  parameter int BITS_DATOS = 8
);
  logic [BITS_DIRECCION-1:0] direccion_mem;
  logic leer;
  logic lectura_completada;
  logic [BITS_DATOS-1:0] dato_mem;
  modport master(output direccion_mem, leer, input lectura_completada, dato_mem);
  modport slave(input direccion_mem, leer, output lectura_completada, dato_mem);
endinterface

// File: rtl/cargador_mascara.sv
// cargador_mascara: reads an NxN mask from memory and streams it out coefficient by coefficient
//   clk, reset (async, active-low)
//   tamano_mascara, direccion_mem_mascara, iniciar_lectura, cancelar : load control
//   mem          : memory read bus (master side)
//   coef_dato, indice_coef, coef_valido : delivered coefficient and its row-major index
//   ocupado, listo, error : status (listo and error are one-cycle pulses)
module cargador_mascara #(
  parameter int BITS_DIRECCION = 16,
  parameter int BITS_DATOS = 8,
  parameter int BITS_TAMANO = 3,
  parameter int TAMANO_MAX = 7,
  parameter int BITS_INDICE = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BITS_TAMANO-1:0] tamano_mascara,
  input  logic [BITS_DIRECCION-1:0] direccion_mem_mascara,
  input  logic                   iniciar_lectura,
  input  logic                   cancelar,
  cargador_mascara_if.master     mem,
  output logic [BITS_DATOS-1:0]  coef_dato,
  output logic [BITS_INDICE-1:0] indice_coef,
  output logic                   coef_valido,
  output logic                   ocupado,
  output logic                   listo,
  output logic                   error
);
  typedef enum logic [2:0] {E_INICIO, E_CALCULO, E_PEDIR, E_ENTREGAR, E_FIN} estado_t;
  estado_t estado_q, estado_d;
  logic [BITS_TAMANO-1:0] tam_q, tam_d;
  logic [BITS_DIRECCION-1:0] base_q, base_d;
  logic [BITS_INDICE-1:0] idx_q, idx_d, ultimo_q, ultimo_d, indice_q, indice_d;
  logic [BITS_DATOS-1:0] dato_q, dato_d;
  logic paso_q, paso_d, error_q, error_d;
  logic invalido;
  assign invalido = tam_q == '0 || !tam_q[0] || 32'(tam_q) > TAMANO_MAX;
  // E_CALCULO lasts two cycles: the first registers N*N-1 and the size verdict,
  // the second shows the error pulse (if any) and branches.
  always_comb begin
    estado_d = estado_q;
    tam_d = tam_q;
    base_d = base_q;
    idx_d = idx_q;
    ultimo_d = ultimo_q;
    indice_d = indice_q;
    dato_d = dato_q;
    paso_d = 1'b0;
    error_d = 1'b0;
    if (estado_q != E_INICIO && cancelar) estado_d = E_INICIO;
    else
      case (estado_q)
        E_INICIO:
          if (iniciar_lectura) begin
            tam_d = tamano_mascara;
            base_d = direccion_mem_mascara;
            idx_d = '0;
            estado_d = E_CALCULO;
          end
        E_CALCULO:
          if (!paso_q) begin
            paso_d = 1'b1;
            error_d = invalido;
            ultimo_d = BITS_INDICE'(tam_q) * BITS_INDICE'(tam_q) - BITS_INDICE'(1);
          end else estado_d = error_q ? E_INICIO : E_PEDIR;
        E_PEDIR:
          if (mem.lectura_completada) begin
            dato_d = mem.dato_mem;
            indice_d = idx_q;
            estado_d = E_ENTREGAR;
          end
        E_ENTREGAR:
          if (idx_q == ultimo_q) estado_d = E_FIN;
          else begin
            idx_d = idx_q + BITS_INDICE'(1);
            estado_d = E_PEDIR;
          end
        default: estado_d = E_INICIO;
      endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      estado_q <= E_INICIO;
      tam_q <= '0;
      base_q <= '0;
      idx_q <= '0;
      ultimo_q <= '0;
      indice_q <= '0;
      dato_q <= '0;
      paso_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      tam_q <= tam_d;
      base_q <= base_d;
      idx_q <= idx_d;
      ultimo_q <= ultimo_d;
      indice_q <= indice_d;
      dato_q <= dato_d;
      paso_q <= paso_d;
      error_q <= error_d;
    end
  assign mem.leer = estado_q == E_PEDIR;
  assign mem.direccion_mem = base_q + BITS_DIRECCION'(idx_q);
  assign coef_dato = dato_q;
  assign indice_coef = indice_q;
  assign coef_valido = estado_q == E_ENTREGAR;
  assign ocupado = estado_q != E_INICIO;
  assign listo = estado_q == E_FIN;
  assign error = error_q;
endmodule

// File: tb/tb_cargador_mascara.sv
// tb_cargador_mascara: scoreboard bench for the mask loader with a behavioural memory
module tb_cargador_mascara;
  localparam int BD = 16, BDT = 8, BT = 4, BI = 6;
  logic clk = 1'b0, reset = 1'b0;
  logic [BT-1:0] tamano_mascara;
  logic [BD-1:0] direccion_mem_mascara;
  logic iniciar_lectura, cancelar;
  logic [BDT-1:0] coef_dato;
  logic [BI-1:0] indice_coef;
  logic coef_valido, ocupado, listo, error;
  cargador_mascara_if #(.BITS_DIRECCION(BD), .BITS_DATOS(BDT)) mem();
  cargador_mascara #(.BITS_DIRECCION(BD), .BITS_DATOS(BDT), .BITS_TAMANO(BT), .TAMANO_MAX(7), .BITS_INDICE(BI)) dut (
    .clk(clk), .reset(reset), .tamano_mascara(tamano_mascara), .direccion_mem_mascara(direccion_mem_mascara),
    .iniciar_lectura(iniciar_lectura), .cancelar(cancelar), .mem(mem), .coef_dato(coef_dato),
    .indice_coef(indice_coef), .coef_valido(coef_valido), .ocupado(ocupado), .listo(listo), .error(error));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [BD-1:0] exp_addr[$], obs_addr[$];
  logic [BI+BDT-1:0] exp_coef[$], obs_coef[$];
  int obs_run[$];
  int listo_cnt, listo_delta, err_cnt, leer_cnt, ocup_cnt, inestable;
  bit timeout;
  logic [34:0] rst_vec;
  function automatic logic [BDT-1:0] f(input logic [BD-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  task automatic prever(input logic [BD-1:0] base, input int nreq, input int ncoef);
    exp_addr.delete();
    exp_coef.delete();
    for (int i = 0; i < nreq; i++) exp_addr.push_back(base + BD'(i));
    for (int i = 0; i < ncoef; i++) exp_coef.push_back({BI'(i), f(base + BD'(i))});
  endtask
  task automatic cargar(input int n, input logic [BD-1:0] base, input int lento, input int espera,
                        input int corte_req, input int corte_ciclo);
    int cnt = 0, req = 0, ult = -100, ciclo;
    logic [BD-1:0] addr_ret = '0;
    obs_addr.delete();
    obs_coef.delete();
    obs_run.delete();
    listo_cnt = 0; listo_delta = 0; err_cnt = 0; leer_cnt = 0; ocup_cnt = 0; inestable = 0;
    tamano_mascara = BT'(n);
    direccion_mem_mascara = base;
    iniciar_lectura = 1'b1;
    @(negedge clk);
    iniciar_lectura = 1'b0;
    for (ciclo = 0; ciclo < 3000; ciclo++) begin
      if (coef_valido) begin obs_coef.push_back({indice_coef, coef_dato}); ult = ciclo; end
      if (listo) begin listo_cnt++; listo_delta = ciclo - ult; end
      if (error) err_cnt++;
      if (ocupado) ocup_cnt++;
      if (mem.leer) begin
        leer_cnt++;
        if (cnt == 0) begin obs_addr.push_back(mem.direccion_mem); addr_ret = mem.direccion_mem; end
        else if (mem.direccion_mem !== addr_ret) inestable++;
      end
      if (ciclo == corte_ciclo) begin
        #3 reset = 1'b0;
        #1 rst_vec = {mem.leer, mem.direccion_mem, coef_dato, indice_coef, coef_valido, ocupado, listo, error};
        break;
      end
      if (!ocupado) break;
      mem.lectura_completada = mem.leer && cnt >= (req == lento ? espera : 0);
      mem.dato_mem = f(mem.direccion_mem);
      cancelar = mem.lectura_completada && req == corte_req;
      if (mem.leer) cnt++;
      if (mem.lectura_completada) begin obs_run.push_back(cnt); cnt = 0; req++; end
      @(negedge clk);
    end
    timeout = ciclo >= 3000;
    mem.lectura_completada = 1'b0;
    cancelar = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if ({mem.leer, mem.direccion_mem, coef_dato, indice_coef} !== '0) begin
      errors++; $display("FAIL reset_bus got %h want 0", {mem.leer, mem.direccion_mem, coef_dato, indice_coef});
    end
    checks++;
    if ({coef_valido, ocupado, listo, error} !== 4'b0) begin
      errors++; $display("FAIL reset_status got %b want 0000", {coef_valido, ocupado, listo, error});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_normal;
    logic [BD-1:0] a, e;
    logic [BI+BDT-1:0] c, ce;
    prever(16'h0100, 9, 9);
    cargar(3, 16'h0100, -1, 0, -1, -1);
    checks++;
    if (timeout || obs_addr.size() != 9 || obs_coef.size() != 9) begin
      errors++; $display("FAIL normal_count got %0d/%0d want 9/9", obs_addr.size(), obs_coef.size());
    end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      a = obs_addr.pop_front(); e = exp_addr.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL normal_addr got %h want %h", a, e); end
    end
    while (exp_coef.size() > 0 && obs_coef.size() > 0) begin
      c = obs_coef.pop_front(); ce = exp_coef.pop_front(); checks++;
      if (c !== ce) begin errors++; $display("FAIL normal_coef got %h want %h", c, ce); end
    end
    checks++;
    if (listo_cnt != 1 || listo_delta != 1) begin
      errors++; $display("FAIL normal_listo got cnt %0d delta %0d want 1 1", listo_cnt, listo_delta);
    end
    checks++;
    if (err_cnt != 0) begin errors++; $display("FAIL normal_error got %0d want 0", err_cnt); end
  endtask
  task automatic test_errores;
    int tams[3] = '{4, 0, 9};
    foreach (tams[i]) begin
      cargar(tams[i], 16'h0200, -1, 0, -1, -1);
      checks++;
      if (timeout || err_cnt != 1 || leer_cnt != 0 || ocup_cnt != 2) begin
        errors++;
        $display("FAIL error_n%0d got err %0d leer %0d ocupado %0d want 1 0 2", tams[i], err_cnt, leer_cnt, ocup_cnt);
      end
    end
  endtask
  task automatic test_wrap;
    logic [BD-1:0] a, e;
    prever(16'hFFFE, 9, 9);
    cargar(3, 16'hFFFE, -1, 0, -1, -1);
    checks++;
    if (timeout || obs_addr.size() != 9 || obs_coef != exp_coef) begin
      errors++; $display("FAIL wrap_coefs got %0d addrs %0d coefs want 9 9", obs_addr.size(), obs_coef.size());
    end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      a = obs_addr.pop_front(); e = exp_addr.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL wrap_addr got %h want %h", a, e); end
    end
  endtask
  task automatic test_espera;
    int r;
    logic [BI+BDT-1:0] c, ce;
    prever(16'h0300, 9, 9);
    cargar(3, 16'h0300, 4, 3, -1, -1);
    checks++;
    if (timeout || obs_addr != exp_addr || inestable != 0) begin
      errors++; $display("FAIL espera_addr got %0d addrs unstable %0d want 9 0", obs_addr.size(), inestable);
    end
    for (int i = 0; i < 9; i++) begin
      r = obs_run.size() > 0 ? obs_run.pop_front() : -1; checks++;
      if (r != (i == 4 ? 4 : 1)) begin errors++; $display("FAIL espera_run%0d got %0d want %0d", i, r, i == 4 ? 4 : 1); end
    end
    while (exp_coef.size() > 0 && obs_coef.size() > 0) begin
      c = obs_coef.pop_front(); ce = exp_coef.pop_front(); checks++;
      if (c !== ce) begin errors++; $display("FAIL espera_coef got %h want %h", c, ce); end
    end
    checks++;
    if (listo_cnt != 1) begin errors++; $display("FAIL espera_listo got %0d want 1", listo_cnt); end
  endtask
  task automatic test_cancelar;
    logic [BI+BDT-1:0] c, ce;
    prever(16'h0400, 5, 4);
    cargar(3, 16'h0400, -1, 0, 4, -1);
    checks++;
    if (timeout || obs_addr != exp_addr || obs_coef != exp_coef) begin
      errors++; $display("FAIL cancel_coefs got %0d coefs want 4", obs_coef.size());
    end
    checks++;
    if (listo_cnt != 0 || err_cnt != 0) begin
      errors++; $display("FAIL cancel_pulses got listo %0d error %0d want 0 0", listo_cnt, err_cnt);
    end
    prever(16'h0500, 25, 25);
    cargar(5, 16'h0500, -1, 0, -1, -1);
    checks++;
    if (timeout || obs_coef.size() != 25 || obs_addr != exp_addr || listo_cnt != 1) begin
      errors++; $display("FAIL n5_count got %0d coefs listo %0d want 25 1", obs_coef.size(), listo_cnt);
    end
    while (exp_coef.size() > 0 && obs_coef.size() > 0) begin
      c = obs_coef.pop_front(); ce = exp_coef.pop_front(); checks++;
      if (c !== ce) begin errors++; $display("FAIL n5_coef got %h want %h", c, ce); end
    end
  endtask
  task automatic test_reset_async;
    prever(16'h0400, 6, 5);
    cargar(3, 16'h0400, -1, 0, -1, 12);
    checks++;
    if (rst_vec !== '0) begin errors++; $display("FAIL async_reset got %h want 0", rst_vec); end
    checks++;
    if (obs_coef != exp_coef || listo_cnt != 0) begin
      errors++; $display("FAIL async_partial got %0d coefs listo %0d want 5 0", obs_coef.size(), listo_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    prever(16'h0600, 9, 9);
    cargar(3, 16'h0600, -1, 0, -1, -1);
    checks++;
    if (timeout || obs_addr != exp_addr || obs_coef != exp_coef || listo_cnt != 1 || ocup_cnt != 21) begin
      errors++;
      $display("FAIL async_reload got %0d coefs listo %0d ocupado %0d want 9 1 21", obs_coef.size(), listo_cnt, ocup_cnt);
    end
  endtask
  initial begin
    tamano_mascara = '0;
    direccion_mem_mascara = '0;
    iniciar_lectura = 1'b0;
    cancelar = 1'b0;
    mem.lectura_completada = 1'b0;
    mem.dato_mem = '0;
    test_reset;
    test_normal;
    test_errores;
    test_wrap;
    test_espera;
    test_cancelar;
    test_reset_async;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
